uart_rx_frame: RTL

Serial receiver and frame parser that sits upstream of the write side of the UART loopback FIFO. It deserialises 8N1 bytes on `RXD` and checks the six-byte debug-assistant frame: `CMD`, `~CMD`, D0, D1, `~CMD`, `CMD`. Only after the whole frame verifies does it write D0 and then D1 into the FIFO that the transmitter drains. Bit timing matches the transmitter: a 20 MHz clock at 256000 baud.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_byte.sv | 97 +++++++++
 rtl/uart_rx_frame.sv | 133 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Constants and helpers shared by the UART receiver and transmitter.
package uart_pkg;

  localparam int unsigned BAUD_CNT_END_DFLT = 78;
  localparam logic [7:0]  CMD_DFLT          = 8'h01;
  localparam int unsigned TIMEOUT_MULT      = 20;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_e;

  // Expected frame: CMD, ~CMD, D0, D1, ~CMD, CMD; the payload steps accept anything.
  function automatic logic step_match(input logic [2:0] step, input logic [7:0] b,
                                      input logic [7:0] cmd);
    case (step)
      3'd0, 3'd5: return b == cmd;
      3'd1, 3'd4: return b == ~cmd;
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, baud counter and byte FSM.
// state   | meaning
// R_IDLE  | line idle, counter held at 0, waiting for a falling edge
// R_START | checking the start bit at mid-bit (high sample = glitch)
// R_DATA  | sampling 8 data bits LSB first
// R_STOP  | sampling the stop bit, then back to idle
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_CNT_END = BAUD_CNT_END_DFLT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rxd_i,
  output logic       byte_valid_o,
  output logic       byte_err_o,
  output logic [7:0] byte_data_o,
  output logic       rx_idle_o,
  output logic       rx_fall_o
);

  localparam logic [15:0] MID_CNT  = 16'(BAUD_CNT_END / 2);
  localparam logic [15:0] WRAP_CNT = 16'(BAUD_CNT_END - 1);

  logic        rxd_s1_q, rxd_s2_q, rxd_prev_q;
  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        fall, mid;

  assign fall = rxd_prev_q & ~rxd_s2_q;
  assign mid  = (cnt_q == MID_CNT);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (state_q == R_IDLE)      cnt_d = '0;
    else if (cnt_q == WRAP_CNT) cnt_d = '0;
    else                        cnt_d = cnt_q + 16'd1;

    case (state_q)
      R_IDLE:  if (fall) state_d = R_START;
      R_START: if (mid) begin
        state_d = rxd_s2_q ? R_IDLE : R_DATA;
        bit_d   = '0;
      end
      R_DATA:  if (mid) begin
        shift_d = {rxd_s2_q, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = R_STOP;
      end
      R_STOP:  if (mid) begin
        state_d = R_IDLE;
        valid_d = rxd_s2_q;
        err_d   = ~rxd_s2_q;
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
      state_q    <= R_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rxd_s1_q   <= rxd_i;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign byte_valid_o = valid_q;
  assign byte_err_o   = err_q;
  assign byte_data_o  = shift_q;
  assign rx_idle_o    = (state_q == R_IDLE);
  assign rx_fall_o    = fall;

endmodule

// File: rtl/uart_rx_frame.sv
// Frame parser for CMD,~CMD,D0,D1,~CMD,CMD; writes D0 then D1 into the FIFO
// only once the whole frame verifies, with an inter-byte timeout.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_CNT_END = BAUD_CNT_END_DFLT,
  parameter logic [7:0]  CMD          = CMD_DFLT
) (
  input  logic       SYS_CLK,
  input  logic       RST_N,
  input  logic       RXD,
  input  logic       WRFULL,
  output logic [7:0] DATA_OUT,
  output logic       WRREQ,
  output logic       WRCLK,
  output logic       FRAME_OK,
  output logic       FRAME_ERR
);

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_MULT * BAUD_CNT_END);

  logic        byte_valid, byte_err, rx_idle, rx_fall;
  logic [7:0]  byte_data;
  logic [2:0]  step_q, step_d;
  logic [7:0]  d0_q, d0_d, d1_q, d1_d;
  logic [15:0] tmo_q, tmo_d;
  logic        wr2_q, wr2_d;
  logic        wrreq_q, wrreq_d;
  logic [7:0]  dout_q, dout_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;

  uart_rx_byte #(.BAUD_CNT_END(BAUD_CNT_END)) u_rx_byte (
    .clk_i        (SYS_CLK),
    .rst_ni       (RST_N),
    .rxd_i        (RXD),
    .byte_valid_o (byte_valid),
    .byte_err_o   (byte_err),
    .byte_data_o  (byte_data),
    .rx_idle_o    (rx_idle),
    .rx_fall_o    (rx_fall)
  );

  always_comb begin
    step_d  = step_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    wr2_d   = 1'b0;
    wrreq_d = 1'b0;
    dout_d  = dout_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;

    if (wr2_q) begin
      wrreq_d = 1'b1;
      dout_d  = d1_q;
    end

    if (step_q == 3'd0 || rx_fall) tmo_d = '0;
    else if (rx_idle)              tmo_d = tmo_q + 16'd1;
    else                           tmo_d = tmo_q;

    if (byte_err) begin
      err_d  = 1'b1;
      step_d = '0;
      d0_d   = '0;
      d1_d   = '0;
    end else if (byte_valid) begin
      if (step_match(step_q, byte_data, CMD)) begin
        if (step_q == 3'd2) d0_d = byte_data;
        if (step_q == 3'd3) d1_d = byte_data;
        if (step_q == 3'd5) begin
          step_d = '0;
          if (WRFULL) begin
            err_d = 1'b1;
          end else begin
            ok_d    = 1'b1;
            wrreq_d = 1'b1;
            dout_d  = d0_q;
            wr2_d   = 1'b1;
          end
        end else begin
          step_d = step_q + 3'd1;
        end
      end else begin
        // A stray CMD byte may be the header of the next frame.
        if (step_q != 3'd0) begin
          err_d = 1'b1;
          d0_d  = '0;
          d1_d  = '0;
        end
        step_d = (byte_data == CMD) ? 3'd1 : 3'd0;
      end
    end else if (tmo_d == TMO_LIMIT) begin
      err_d  = 1'b1;
      step_d = '0;
      tmo_d  = '0;
      d0_d   = '0;
      d1_d   = '0;
    end
  end

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      step_q  <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
      tmo_q   <= '0;
      wr2_q   <= 1'b0;
      wrreq_q <= 1'b0;
      dout_q  <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      step_q  <= step_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      tmo_q   <= tmo_d;
      wr2_q   <= wr2_d;
      wrreq_q <= wrreq_d;
      dout_q  <= dout_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign DATA_OUT  = dout_q;
  assign WRREQ     = wrreq_q;
  assign WRCLK     = ~SYS_CLK;
  assign FRAME_OK  = ok_q;
  assign FRAME_ERR = err_q;

endmodule
